// File: rtl/mdr_seq_ctrl.sv
// MDR/RAM load-store sequencer: one LDR/STR in flight, Moore-style registered strobes.
// Optional MDR_ACC_CNT_EN adds per-op completion counters (ld_cnt, st_cnt).
module mdr_seq_ctrl #(
  parameter int AW       = 16,
  parameter int RAM_WAIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [1:0]    op,
  input  logic [AW-1:0] addr,
  input  logic [2:0]    rd,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    en_mdr,
  output logic [AW-1:0] ram_addr,
  output logic          ram_re,
  output logic          ram_we,
  output logic          reg_we,
  output logic [2:0]    reg_waddr
`ifdef MDR_ACC_CNT_EN
  ,
  output logic [15:0]   ld_cnt,
  output logic [15:0]   st_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_LATCH,
    RD_WB,
    WR_LATCH,
    WR_MEM,
    DONE
  } state_t;

  localparam logic [1:0] OP_LDR = 2'b01;
  localparam logic [1:0] OP_STR = 2'b10;
  localparam logic [1:0] EN_RAM = 2'b01;
  localparam logic [1:0] EN_REG = 2'b10;
  localparam logic [3:0] WAIT_INIT = 4'(RAM_WAIT);

  state_t     state;
  state_t     nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       accept;
  logic       bad_op;

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    accept  = 1'b0;
    bad_op  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          unique case (1'b1)
            (op == OP_LDR): begin
              accept  = 1'b1;
              cnt_nxt = WAIT_INIT;
              nxt     = (RAM_WAIT == 0) ? RD_LATCH : RD_WAIT;
            end
            (op == OP_STR): begin
              accept = 1'b1;
              nxt    = WR_LATCH;
            end
            default: bad_op = 1'b1;
          endcase
        end
      end
      RD_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) nxt = RD_LATCH;
      end
      RD_LATCH: nxt = RD_WB;
      RD_WB:    nxt = DONE;
      WR_LATCH: nxt = WR_MEM;
      WR_MEM:   nxt = DONE;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      en_mdr    <= 2'b00;
      ram_addr  <= '0;
      ram_re    <= 1'b0;
      ram_we    <= 1'b0;
      reg_we    <= 1'b0;
      reg_waddr <= 3'd0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        ram_addr  <= addr;
        reg_waddr <= rd;
      end
      busy   <= !(nxt inside {IDLE, DONE});
      done   <= (nxt == DONE);
      err    <= bad_op;
      ram_re <= (nxt inside {RD_WAIT, RD_LATCH, RD_WB});
      ram_we <= (nxt == WR_MEM);
      reg_we <= (nxt == RD_WB);
      unique case (1'b1)
        (nxt inside {RD_LATCH, RD_WB}):  en_mdr <= EN_RAM;
        (nxt inside {WR_LATCH, WR_MEM}): en_mdr <= EN_REG;
        default:                         en_mdr <= 2'b00;
      endcase
    end
  end

`ifdef MDR_ACC_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_cnt <= 16'd0;
      st_cnt <= 16'd0;
    end else begin
      if (state == RD_WB)  ld_cnt <= ld_cnt + 16'd1;
      if (state == WR_MEM) st_cnt <= st_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mdr_seq_ctrl.sv
// Directed bench for mdr_seq_ctrl with a small MDR/RAM model.
// Runs RAM_WAIT=1 and RAM_WAIT=0 instances side by side.
module tb_mdr_seq_ctrl;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [AW-1:0] addr = '0;
  logic [2:0]    rd = 3'd0;

  logic          busy, done, err, ram_re, ram_we, reg_we;
  logic [1:0]    en_mdr;
  logic [AW-1:0] ram_addr;
  logic [2:0]    reg_waddr;
  logic          busy0, done0, err0, ram_re0, ram_we0, reg_we0;
  logic [1:0]    en_mdr0;
  logic [AW-1:0] ram_addr0;
  logic [2:0]    reg_waddr0;
`ifdef MDR_ACC_CNT_EN
  logic [15:0]   ld_cnt, st_cnt, ld_cnt0, st_cnt0;
`endif

  mdr_seq_ctrl #(.AW(AW), .RAM_WAIT(1)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .rd(rd),
    .busy(busy), .done(done), .err(err), .en_mdr(en_mdr),
    .ram_addr(ram_addr), .ram_re(ram_re), .ram_we(ram_we),
    .reg_we(reg_we), .reg_waddr(reg_waddr)
`ifdef MDR_ACC_CNT_EN
    , .ld_cnt(ld_cnt), .st_cnt(st_cnt)
`endif
  );

  mdr_seq_ctrl #(.AW(AW), .RAM_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .rd(rd),
    .busy(busy0), .done(done0), .err(err0), .en_mdr(en_mdr0),
    .ram_addr(ram_addr0), .ram_re(ram_re0), .ram_we(ram_we0),
    .reg_we(reg_we0), .reg_waddr(reg_waddr0)
`ifdef MDR_ACC_CNT_EN
    , .ld_cnt(ld_cnt0), .st_cnt(st_cnt0)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  logic [15:0] mdr;
  logic [15:0] reg_data = 16'h0;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = 8'h0;
  logic [15:0] pl_data = 16'h0;

  always @(posedge clk or negedge rst) begin
    if (!rst) mdr <= 16'h0;
    else begin
      case (en_mdr)
        2'b01:   mdr <= ram_re ? mem[ram_addr[7:0]] : 16'hDEAD;
        2'b10:   mdr <= reg_data;
        default: mdr <= 16'h0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_we) mem[ram_addr[7:0]] <= mdr;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [2:0]  rd;
    logic [15:0] data;
    int          done_c;
    int          done0_c;
    int          latch_c;
    logic [1:0]  latch_en;
    int          wb_c;
    int          we_c;
    int          err_n;
  } vec_t;

  vec_t vt [6];

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int done_c = 0, done0_c = 0, latch_c = 0, wb_c = 0, we_c = 0;
    int err_n = 0, busy_bad = 0, ov_bad = 0, addr_bad = 0;
    logic [1:0] latch_en = 2'b00;
    logic [15:0] wb_mdr = 16'h0;
    logic [2:0] wb_addr = 3'd0;
    logic exp_busy;
    if (v.op == 2'b01) preload(v.addr[7:0], v.data);
    else reg_data = v.data;
    @(negedge clk);
    req = 1'b1; op = v.op; addr = v.addr; rd = v.rd;
    @(posedge clk);
    #1 req = 1'b0; op = 2'b00; addr = '0; rd = 3'd0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done && done_c == 0) done_c = c;
      if (done0 && done0_c == 0) done0_c = c;
      if (en_mdr != 2'b00 && latch_c == 0) begin
        latch_c = c; latch_en = en_mdr;
      end
      if (reg_we && wb_c == 0) begin
        wb_c = c; wb_mdr = mdr; wb_addr = reg_waddr;
      end
      if (ram_we && we_c == 0) we_c = c;
      if (err) err_n++;
      exp_busy = (v.done_c != 0) && (c < v.done_c);
      if (busy !== exp_busy) busy_bad++;
      if (en_mdr == 2'b11 || en_mdr0 == 2'b11 ||
          (ram_re && ram_we) || (ram_re0 && ram_we0)) ov_bad++;
      if (busy && ram_addr !== v.addr) addr_bad++;
    end
    chk($sformatf("v%0d done_cycle", id), done_c, v.done_c);
    chk($sformatf("v%0d done_cycle_rw0", id), done0_c, v.done0_c);
    chk($sformatf("v%0d latch_cycle", id), latch_c, v.latch_c);
    chk($sformatf("v%0d latch_en", id), {30'd0, latch_en}, {30'd0, v.latch_en});
    chk($sformatf("v%0d regwe_cycle", id), wb_c, v.wb_c);
    chk($sformatf("v%0d ramwe_cycle", id), we_c, v.we_c);
    chk($sformatf("v%0d err_pulses", id), err_n, v.err_n);
    chk($sformatf("v%0d busy_bad", id), busy_bad, 0);
    chk($sformatf("v%0d overlap_bad", id), ov_bad, 0);
    chk($sformatf("v%0d ram_addr_bad", id), addr_bad, 0);
    if (v.op == 2'b01) begin
      chk($sformatf("v%0d mdr_at_wb", id), {16'd0, wb_mdr}, {16'd0, v.data});
      chk($sformatf("v%0d reg_waddr", id), {29'd0, wb_addr}, {29'd0, v.rd});
    end
    if (v.op == 2'b10)
      chk($sformatf("v%0d ram_data", id), {16'd0, mem[v.addr[7:0]]},
          {16'd0, v.data});
  endtask

  initial begin
    int d1, b4, e4, b5, d2, ovl;
    vt[0] = '{2'b01, 16'h0040, 3'd3, 16'hBEEF, 4, 3, 2, 2'b01, 3, 0, 0};
    vt[1] = '{2'b10, 16'h0011, 3'd0, 16'h1234, 3, 3, 1, 2'b10, 0, 2, 0};
    vt[2] = '{2'b11, 16'h0077, 3'd5, 16'h0000, 0, 0, 0, 2'b00, 0, 0, 1};
    vt[3] = '{2'b00, 16'h0033, 3'd1, 16'h0000, 0, 0, 0, 2'b00, 0, 0, 1};
    vt[4] = '{2'b01, 16'h00FF, 3'd7, 16'h5A5A, 4, 3, 2, 2'b01, 3, 0, 0};
    vt[5] = '{2'b10, 16'h0000, 3'd2, 16'hFFFF, 3, 3, 1, 2'b10, 0, 2, 0};

    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {5'd0, busy, done, err, en_mdr, ram_re, ram_we, reg_we, ram_addr, reg_waddr},
        32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
`ifdef MDR_ACC_CNT_EN
    chk("cnt_reset", {ld_cnt, st_cnt}, 32'd0);
`endif

    for (int i = 0; i < 6; i++) run_vec(i, vt[i]);

`ifdef MDR_ACC_CNT_EN
    chk("ld_cnt", {16'd0, ld_cnt}, 32'd2);
    chk("st_cnt", {16'd0, st_cnt}, 32'd2);
`endif

    // req held high: second STR must start only in the IDLE cycle after DONE
    reg_data = 16'h7777;
    @(negedge clk);
    req = 1'b1; op = 2'b10; addr = 16'h0022; rd = 3'd0;
    @(posedge clk);
    d1 = 0; b4 = 1; e4 = 1; b5 = 0; d2 = 0; ovl = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (done && d1 == 0) d1 = c;
      else if (done && d2 == 0) d2 = c;
      if (c == 4) begin b4 = busy; e4 = en_mdr; end
      if (c == 5) b5 = busy;
      if (ram_re && ram_we) ovl++;
    end
    req = 1'b0; op = 2'b00;
    chk("held_done1", d1, 3);
    chk("held_idle_busy", b4, 0);
    chk("held_idle_en_mdr", e4, 0);
    chk("held_accept_busy", b5, 1);
    chk("held_done2", d2, 7);
    chk("held_overlap", ovl, 0);
    chk("held_ram_data", {16'd0, mem[8'h22]}, 32'h7777);
    repeat (3) @(negedge clk);

    // async reset while in RD_WB
    preload(8'h40, 16'hCAFE);
    @(negedge clk);
    req = 1'b1; op = 2'b01; addr = 16'h0040; rd = 3'd6;
    @(posedge clk);
    #1 req = 1'b0; op = 2'b00;
    repeat (3) @(negedge clk);
    chk("pre_reset_reg_we", {31'd0, reg_we}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("reset_mid_txn",
        {5'd0, busy, done, err, en_mdr, ram_re, ram_we, reg_we, ram_addr, reg_waddr},
        32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_busy", {30'd0, busy, done}, 32'd0);
    run_vec(6, vt[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
